// File: rtl/multi_port_stream_issuer_pkg.sv
// Shared defaults and sizing helpers for the multi-port stream issuer.
package multi_port_stream_issuer_pkg;

    localparam int unsigned DefLaneNum   = 4;
    localparam int unsigned DefDataWidth = 32;

    // Bits needed to hold a count in the range 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multi_port_stream_issuer_lane_compactor.sv
// Packs the masked lanes of a bundle into slots 0..k-1 in ascending lane order.
module stream_lane_compactor
    import multi_port_stream_issuer_pkg::*;
#(
    parameter int unsigned LaneNum   = DefLaneNum,
    parameter int unsigned DataWidth = DefDataWidth
) (
    input  logic [LaneNum-1:0]                       mask_i,
    input  logic [LaneNum-1:0][DataWidth-1:0]        payload_i,
    output logic [LaneNum-1:0][DataWidth-1:0]        payload_o,
    output logic [$clog2(LaneNum+1)-1:0]             cnt_o
);

    localparam int unsigned CntW = cnt_width(LaneNum);
    localparam int unsigned IdxW = (LaneNum > 1) ? $clog2(LaneNum) : 1;

    logic [CntW-1:0] pos;

    always_comb begin
        payload_o = '0;
        pos       = '0;
        for (int i = 0; i < LaneNum; i++) begin
            if (mask_i[i]) begin
                payload_o[IdxW'(pos)] = payload_i[i];
                pos                   = pos + CntW'(1);
            end
        end
        cnt_o = pos;
    end

endmodule

// File: rtl/multi_port_stream_issuer.sv
// Holds one compacted bundle and issues it as a contiguous lane prefix into a multi-port FIFO.
module multi_port_stream_issuer
    import multi_port_stream_issuer_pkg::*;
#(
    parameter int unsigned LaneNum   = DefLaneNum,
    parameter int unsigned DataWidth = DefDataWidth
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_vld_i,
    input  logic [LaneNum-1:0]                  in_mask_i,
    input  logic [LaneNum-1:0][DataWidth-1:0]   in_payload_i,
    output logic                                in_rdy_o,
    output logic [LaneNum-1:0]                  out_vld_o,
    output logic [LaneNum-1:0][DataWidth-1:0]   out_payload_o,
    input  logic [LaneNum-1:0]                  out_rdy_i,
    input  logic                                flush_i,
    output logic                                busy_o
);

    localparam int unsigned CntW = cnt_width(LaneNum);

    logic [CntW-1:0]                    cnt_q, cnt_d;
    logic [LaneNum-1:0][DataWidth-1:0]  slot_q, slot_d;

    logic [LaneNum-1:0]                 used;
    logic [LaneNum-1:0]                 fire;
    logic [CntW-1:0]                    acc_cnt;
    logic                               load;

    logic [LaneNum-1:0][DataWidth-1:0]  load_payload;
    logic [CntW-1:0]                    load_cnt;
    logic [LaneNum-1:0][DataWidth-1:0]  shift_payload;
    logic [CntW-1:0]                    shift_cnt;

    // Valid only on a prefix: lane i fires when all lower lanes are ready.
    always_comb begin
        logic run;
        used      = '0;
        out_vld_o = '0;
        run       = 1'b1;
        for (int i = 0; i < LaneNum; i++) begin
            used[i]      = (CntW'(i) < cnt_q);
            out_vld_o[i] = used[i] & run;
            run          = run & out_rdy_i[i];
        end
        fire    = out_vld_o & out_rdy_i;
        acc_cnt = '0;
        for (int i = 0; i < LaneNum; i++) begin
            acc_cnt = acc_cnt + CntW'(fire[i]);
        end
    end

    assign out_payload_o = slot_q;
    assign busy_o        = (cnt_q != '0);
    assign in_rdy_o      = ~flush_i & ((cnt_q == '0) | (acc_cnt == cnt_q));
    assign load          = in_vld_i & in_rdy_o;

    stream_lane_compactor #(
        .LaneNum   (LaneNum),
        .DataWidth (DataWidth)
    ) u_load_compactor (
        .mask_i    (in_mask_i),
        .payload_i (in_payload_i),
        .payload_o (load_payload),
        .cnt_o     (load_cnt)
    );

    // Leftover entries after a partial drain are re-packed down to slot 0.
    stream_lane_compactor #(
        .LaneNum   (LaneNum),
        .DataWidth (DataWidth)
    ) u_shift_compactor (
        .mask_i    (used & ~fire),
        .payload_i (slot_q),
        .payload_o (shift_payload),
        .cnt_o     (shift_cnt)
    );

    always_comb begin
        cnt_d  = cnt_q;
        slot_d = slot_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d  = load_cnt;
            slot_d = load_payload;
        end else if (acc_cnt != '0) begin
            cnt_d  = shift_cnt;
            slot_d = shift_payload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Payload storage is qualified by cnt_q, so it carries no reset.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

endmodule

// File: tb/tb_multi_port_stream_issuer.sv
// Scoreboard bench for multi_port_stream_issuer with LaneNum=4, DataWidth=32.
module tb_multi_port_stream_issuer;

    localparam int unsigned LN = 4;
    localparam int unsigned DW = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_vld_i;
    logic [LN-1:0]            in_mask_i;
    logic [LN-1:0][DW-1:0]    in_payload_i;
    logic                     in_rdy_o;
    logic [LN-1:0]            out_vld_o;
    logic [LN-1:0][DW-1:0]    out_payload_o;
    logic [LN-1:0]            out_rdy_i;
    logic                     flush_i;
    logic                     busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    multi_port_stream_issuer #(.LaneNum(LN), .DataWidth(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_vld_i      (in_vld_i),
        .in_mask_i     (in_mask_i),
        .in_payload_i  (in_payload_i),
        .in_rdy_o      (in_rdy_o),
        .out_vld_o     (out_vld_o),
        .out_payload_o (out_payload_o),
        .out_rdy_i     (out_rdy_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard push: every accepted bundle contributes its masked lanes in order.
    always @(negedge clk) begin
        if (!rst && in_vld_i && in_rdy_o) begin
            for (int i = 0; i < LN; i++) begin
                if (in_mask_i[i]) exp_q.push_back(in_payload_i[i]);
            end
        end
    end

    // Monitor: each firing lane consumes the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !flush_i) begin
            for (int i = 0; i < LN; i++) begin
                if (out_vld_o[i] && out_rdy_i[i]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_unexpected lane %0d: got %h expected none", i, out_payload_o[i]);
                    end else begin
                        logic [DW-1:0] e;
                        e = exp_q.pop_front();
                        if (out_payload_o[i] !== e) begin
                            n_fail++;
                            $display("FAIL mon_payload lane %0d: got %h expected %h", i, out_payload_o[i], e);
                        end
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    localparam logic [DW-1:0] A = 32'hA000_0001;
    localparam logic [DW-1:0] B = 32'hB000_0002;
    localparam logic [DW-1:0] C = 32'hC000_0003;
    localparam logic [DW-1:0] D = 32'hD000_0004;

    initial begin
        int guard;
        int seq;
        rst          = 1'b1;
        in_vld_i     = 1'b0;
        in_mask_i    = '0;
        in_payload_i = '0;
        out_rdy_i    = '1;
        flush_i      = 1'b0;

        // Reset state
        repeat (2) at_neg();
        check("rst_out_vld", 32'(out_vld_o), 32'h0);
        check("rst_busy",    32'(busy_o),    32'h0);
        check("rst_in_rdy",  32'(in_rdy_o),  32'h1);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Full-ready load of 1011
        out_rdy_i    = 4'b1111;
        in_vld_i     = 1'b1;
        in_mask_i    = 4'b1011;
        in_payload_i = {D, C, B, A};
        at_neg();
        check("t1_in_rdy", 32'(in_rdy_o), 32'h1);
        next_cycle();
        in_vld_i = 1'b0;
        at_neg();
        check("t1_out_vld", 32'(out_vld_o), 32'h7);
        check("t1_lane0", out_payload_o[0], A);
        check("t1_lane1", out_payload_o[1], B);
        check("t1_lane2", out_payload_o[2], D);
        check("t1_in_rdy_drain", 32'(in_rdy_o), 32'h1);
        next_cycle();
        at_neg();
        check("t1_busy_after", 32'(busy_o), 32'h0);
        check("t1_vld_after", 32'(out_vld_o), 32'h0);

        // Partial ready 1101: only lane 0 is accepted each cycle
        next_cycle();
        out_rdy_i = 4'b1101;
        in_vld_i  = 1'b1;
        at_neg();
        next_cycle();
        in_vld_i = 1'b0;
        at_neg();
        check("t2_c1_vld", 32'(out_vld_o), 32'h3);
        check("t2_c1_lane0", out_payload_o[0], A);
        check("t2_c1_in_rdy", 32'(in_rdy_o), 32'h0);
        next_cycle();
        at_neg();
        check("t2_c2_lane0", out_payload_o[0], B);
        check("t2_c2_lane1", out_payload_o[1], D);
        check("t2_c2_in_rdy", 32'(in_rdy_o), 32'h0);
        next_cycle();
        at_neg();
        check("t2_c3_vld", 32'(out_vld_o), 32'h1);
        check("t2_c3_lane0", out_payload_o[0], D);
        check("t2_c3_in_rdy", 32'(in_rdy_o), 32'h1);
        next_cycle();

        // Back-to-back full bundles
        out_rdy_i = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            in_vld_i     = 1'b1;
            in_mask_i    = 4'b1111;
            in_payload_i = {32'(b*4+3) | 32'h5000_0000, 32'(b*4+2) | 32'h5000_0000,
                            32'(b*4+1) | 32'h5000_0000, 32'(b*4)   | 32'h5000_0000};
            at_neg();
            check("t3_in_rdy", 32'(in_rdy_o), 32'h1);
            if (b > 0) check("t3_out_vld", 32'(out_vld_o), 32'hF);
            next_cycle();
        end
        in_vld_i = 1'b0;
        next_cycle();

        // Empty mask
        in_vld_i  = 1'b1;
        in_mask_i = 4'b0000;
        at_neg();
        check("t4_in_rdy", 32'(in_rdy_o), 32'h1);
        next_cycle();
        in_vld_i = 1'b0;
        at_neg();
        check("t4_busy", 32'(busy_o), 32'h0);
        check("t4_vld",  32'(out_vld_o), 32'h0);
        next_cycle();

        // Flush with a competing bundle, then reset mid-issue
        out_rdy_i    = 4'b0000;
        in_vld_i     = 1'b1;
        in_mask_i    = 4'b0111;
        in_payload_i = {D, C, B, A};
        next_cycle();
        in_vld_i = 1'b0;
        at_neg();
        check("t5_busy_held", 32'(busy_o), 32'h1);
        check("t5_vld_held",  32'(out_vld_o), 32'h1);
        next_cycle();
        flush_i   = 1'b1;
        in_vld_i  = 1'b1;
        in_mask_i = 4'b1111;
        at_neg();
        check("t5_flush_in_rdy", 32'(in_rdy_o), 32'h0);
        check("t5_flush_vld",    32'(out_vld_o), 32'h1);
        next_cycle();
        exp_q.delete();
        flush_i  = 1'b0;
        in_vld_i = 1'b0;
        at_neg();
        check("t5_after_busy", 32'(busy_o), 32'h0);
        check("t5_after_vld",  32'(out_vld_o), 32'h0);
        next_cycle();
        in_vld_i  = 1'b1;
        in_mask_i = 4'b1111;
        next_cycle();
        in_vld_i  = 1'b0;
        out_rdy_i = 4'b0001;
        at_neg();
        check("t5_issue_busy", 32'(busy_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("t5_rst_vld",    32'(out_vld_o), 32'h0);
        check("t5_rst_busy",   32'(busy_o),    32'h0);
        check("t5_rst_in_rdy", 32'(in_rdy_o),  32'h1);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        at_neg();
        check("t5_post_rst_vld", 32'(out_vld_o), 32'h0);
        next_cycle();

        // Random ready and random masks against the scoreboard
        seq = 0;
        for (int c = 0; c < 300; c++) begin
            out_rdy_i = 4'($urandom_range(0, 15));
            if (!in_vld_i || in_rdy_o) begin
                in_vld_i  = ($urandom_range(0, 3) != 0);
                in_mask_i = 4'($urandom_range(0, 15));
                for (int i = 0; i < LN; i++) begin
                    in_payload_i[i] = 32'h7700_0000 | 32'(seq);
                    seq++;
                end
            end
            next_cycle();
        end
        in_vld_i  = 1'b0;
        out_rdy_i = 4'b1111;
        guard = 0;
        while ((busy_o || exp_q.size() != 0) && guard < 50) begin
            next_cycle();
            guard++;
        end
        at_neg();
        check("t6_drain_busy", 32'(busy_o), 32'h0);
        check("t6_sb_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_port_stream_issuer.md
MULTI_PORT_STREAM_ISSUER -- requirements
Module: multi_port_stream_issuer

Interface
REQ-001 Parameter LaneNum, default 4: number of lanes in the input bundle and of output enqueue ports.
REQ-002 Parameter DataWidth, default 32: payload width per lane.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_vld_i  input  1  input bundle valid.
REQ-006 in_mask_i  input  LaneNum  per-lane entry-present mask of the bundle.
REQ-007 in_payload_i  input  LaneNum x DataWidth  bundle payload, lane-indexed.
REQ-008 in_rdy_o  output  1  bundle accepted when in_vld_i & in_rdy_o.
REQ-009 out_vld_o  output  LaneNum  per-lane enqueue valid toward a multi-port FIFO.
REQ-010 out_payload_o  output  LaneNum x DataWidth  per-lane enqueue payload.
REQ-011 out_rdy_i  input  LaneNum  per-lane enqueue ready; must not depend combinationally on out_vld_o.
REQ-012 flush_i  input  1  synchronous discard of all held entries.
REQ-013 busy_o  output  1  high while any held entry remains.

Function
REQ-014 The block SHALL hold one compacted bundle: entry slots 0..LaneNum-1 plus count cnt_q, width $clog2(LaneNum+1).
REQ-015 On bundle acceptance, the set entries of in_mask_i SHALL be packed into slots 0..k-1 in ascending lane order, with cnt_q set to k = popcount(in_mask_i).
REQ-016 Latency SHALL be one cycle: a bundle accepted at edge N appears on the out lanes from cycle N+1.
REQ-017 out_vld_o[i] SHALL be (i < cnt_q) & (AND of out_rdy_i[i-1:0]), so that only a contiguous prefix of lanes fires; out_vld_o[0] = (cnt_q > 0).
REQ-018 out_payload_o[i] SHALL equal slot i; the value when out_vld_o[i]=0 is don't-care.
REQ-019 Accepted count a = number of lanes with out_vld_o & out_rdy_i; the remaining entries SHALL shift down by a, and cnt_q becomes cnt_q - a, preserving order.
REQ-020 in_rdy_o SHALL be high when ~flush_i & (cnt_q == 0 or a == cnt_q), so a new bundle loads in the same cycle the last entries drain (full throughput).
REQ-021 A bundle with in_mask_i == 0 SHALL be accepted and discarded; cnt_q stays 0 and no out_vld_o asserts.
REQ-022 Order: an entry SHALL never issue before any entry of an earlier bundle or a lower lane of the same bundle.
REQ-023 flush_i SHALL set cnt_q to 0 at the next edge, drop any drain/load in that cycle, and force in_rdy_o low; out_vld_o keeps its normal value during the flush cycle.
REQ-024 busy_o SHALL equal (cnt_q != 0).
REQ-025 If out_rdy_i is all-zero, slots and cnt_q SHALL hold unchanged indefinitely.

Reset
REQ-026 While rst is high: cnt_q = 0, out_vld_o = 0, busy_o = 0, and in_rdy_o = 1 (after any flush_i gating).
REQ-027 Payload slots SHALL NOT be reset; they are written only on load or shift.
REQ-028 Reset asserted mid-issue SHALL discard all held entries with no partial output afterwards.

Structure
REQ-029 No package typedefs are required; count width and shift amount SHALL be derived locally from LaneNum.
REQ-030 The mask-to-slot packing SHALL be a sub-module stream_lane_compactor (mask + payload in, packed payload + count out), reusable for the shift-down step.
REQ-031 Target size is 120-400 RTL lines, with no combinational path from in_vld_i to out_vld_o.

Verification (LaneNum=4, DataWidth=32)
REQ-032 Load mask 4'b1011, payload {D,C,B,A}, with out_rdy_i = 4'b1111 -> next cycle out_vld_o = 4'b0111 with lanes 0..2 = A,B,D; in_rdy_o = 1 and cnt_q goes to 0.
REQ-033 Same load with out_rdy_i = 4'b1101 -> cycle 1 fires only lane 0 (A), cnt_q = 2; cycle 2 shows B,D on lanes 0..1; in_rdy_o = 0 until B,D drain.
REQ-034 Back-to-back full bundles with out_rdy_i = all ones -> one bundle issued per cycle, and in_rdy_o stays high.
REQ-035 Load mask 4'b0000 -> accepted, busy_o stays 0, and no out_vld_o asserts.
REQ-036 Hold 3 entries, assert flush_i together with in_vld_i -> bundle not accepted and cnt_q = 0 next cycle; then assert rst mid-issue -> all outputs go to reset values immediately.
REQ-037 Random out_rdy_i with a scoreboard -> the output sequence equals the input masked-entry sequence, with no loss, duplication, or reordering.
